obstacle_gen: RTL



---
 rtl/obstacle_gen_if.sv | 23 ++
 rtl/obstacle_gen.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/obstacle_gen_if.sv
// Game-side bus of obstacle_gen: game mode in, per-slot obstacle rectangles and pass count out.
interface obstacle_gen_if #(
    parameter int NUM_OBS = 10
);
    logic [1:0]              gamemode;
    logic [NUM_OBS-1:0][9:0] obstacle_x_left;
    logic [NUM_OBS-1:0][9:0] obstacle_x_right;
    logic [NUM_OBS-1:0][8:0] obstacle_y_up;
    logic [NUM_OBS-1:0][8:0] obstacle_y_down;
    logic [15:0]             obstacles_passed;

    modport master (
        output gamemode,
        input  obstacle_x_left, obstacle_x_right, obstacle_y_up, obstacle_y_down,
        input  obstacles_passed
    );

    modport slave (
        input  gamemode,
        output obstacle_x_left, obstacle_x_right, obstacle_y_up, obstacle_y_down,
        output obstacles_passed
    );
endinterface

// File: rtl/obstacle_gen.sv
// Scrolling obstacle generator: fixed pool of slots, LFSR-placed spawns, leftward scroll, retire count.
// Optional macro OBSTACLE_SPEEDUP_EN raises scroll speed with the number of obstacles passed.
module obstacle_gen #(
    parameter int          NUM_OBS        = 10,
    parameter int          SPAWN_X        = 640,
    parameter int          OBS_WIDTH      = 40,
    parameter int          SPAWN_INTERVAL = 90,
    parameter int          BASE_SPEED     = 4,
    parameter int          UPPER_BOUND    = 20,
    parameter int          LOWER_BOUND    = 460,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input logic           clk,
    input logic           rst_n,
    obstacle_gen_if.slave bus
);
    localparam logic [1:0] GM_CLEAR = 2'b00;
    localparam logic [1:0] GM_RUN   = 2'b01;
    localparam int         CNT_W    = $clog2(NUM_OBS + 1);

    logic [NUM_OBS-1:0]       active,  active_nxt;
    logic [NUM_OBS-1:0][9:0]  x_left,  x_left_nxt;
    logic [NUM_OBS-1:0][9:0]  x_right, x_right_nxt;
    logic [NUM_OBS-1:0][8:0]  y_up,    y_up_nxt;
    logic [NUM_OBS-1:0][8:0]  y_down,  y_down_nxt;
    logic [6:0]               spawn_cnt, spawn_cnt_nxt;
    logic [15:0]              lfsr, lfsr_nxt;
    logic [15:0]              passed, passed_nxt;
    logic [3:0]               speed;

`ifdef OBSTACLE_SPEEDUP_EN
    logic [12:0] speed_raw;
    assign speed_raw = 13'(BASE_SPEED) + passed[15:3];
    assign speed     = (speed_raw > 13'd8) ? 4'd8 : speed_raw[3:0];
`else
    assign speed = 4'(BASE_SPEED);
`endif

    // Spawn geometry uses the LFSR value before this edge's advance.
    logic [8:0]  spawn_y_up;
    logic [10:0] spawn_y_down_raw;
    logic [8:0]  spawn_y_down;
    assign spawn_y_up       = 9'(UPPER_BOUND) + {1'b0, lfsr[7:0]};
    assign spawn_y_down_raw = {2'b00, spawn_y_up} + 11'd40 + {4'd0, lfsr[12:8], 2'b00};
    assign spawn_y_down     = (spawn_y_down_raw > 11'(LOWER_BOUND)) ? 9'(LOWER_BOUND)
                                                                    : spawn_y_down_raw[8:0];

    logic               at_interval;
    logic               slot_found;
    logic [NUM_OBS-1:0] spawn_sel;
    logic [CNT_W-1:0]   retire_cnt;
    logic [16:0]        passed_sum;

    assign at_interval = (spawn_cnt == 7'(SPAWN_INTERVAL - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        active_nxt    = active;
        x_left_nxt    = x_left;
        x_right_nxt   = x_right;
        y_up_nxt      = y_up;
        y_down_nxt    = y_down;
        spawn_cnt_nxt = spawn_cnt;
        lfsr_nxt      = lfsr;
        passed_nxt    = passed;
        spawn_sel     = '0;
        slot_found    = 1'b0;
        retire_cnt    = '0;
        passed_sum    = '0;

        // Free slots come from the registered state, so a slot retiring now is not reusable yet.
        for (int i = 0; i < NUM_OBS; i++) begin
            if (!active[i] && !slot_found) begin
                spawn_sel[i] = 1'b1;
                slot_found   = 1'b1;
            end
        end

        if (bus.gamemode == GM_CLEAR) begin
            active_nxt    = '0;
            x_left_nxt    = '0;
            x_right_nxt   = '0;
            y_up_nxt      = '0;
            y_down_nxt    = '0;
            spawn_cnt_nxt = '0;
            lfsr_nxt      = LFSR_SEED;
            passed_nxt    = '0;
        end else if (bus.gamemode == GM_RUN) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (active[i]) begin
                    if (x_right[i] <= 10'(speed)) begin
                        active_nxt[i]  = 1'b0;
                        x_left_nxt[i]  = '0;
                        x_right_nxt[i] = '0;
                        y_up_nxt[i]    = '0;
                        y_down_nxt[i]  = '0;
                        retire_cnt     = retire_cnt + CNT_W'(1);
                    end else begin
                        x_left_nxt[i]  = (x_left[i] > 10'(speed)) ? x_left[i] - 10'(speed) : '0;
                        x_right_nxt[i] = x_right[i] - 10'(speed);
                    end
                end else if (at_interval && spawn_sel[i]) begin
                    active_nxt[i]  = 1'b1;
                    x_left_nxt[i]  = 10'(SPAWN_X);
                    x_right_nxt[i] = 10'(SPAWN_X + OBS_WIDTH);
                    y_up_nxt[i]    = spawn_y_up;
                    y_down_nxt[i]  = spawn_y_down;
                end
            end

            if (at_interval)
                spawn_cnt_nxt = slot_found ? '0 : spawn_cnt;
            else
                spawn_cnt_nxt = spawn_cnt + 7'd1;

            passed_sum = {1'b0, passed} + 17'(retire_cnt);
            passed_nxt = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];
            lfsr_nxt   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '0;
            x_left    <= '0;
            x_right   <= '0;
            y_up      <= '0;
            y_down    <= '0;
            spawn_cnt <= '0;
            lfsr      <= LFSR_SEED;
            passed    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            active    <= active_nxt;
            x_left    <= x_left_nxt;
            x_right   <= x_right_nxt;
            y_up      <= y_up_nxt;
            y_down    <= y_down_nxt;
            spawn_cnt <= spawn_cnt_nxt;
            lfsr      <= lfsr_nxt;
            passed    <= passed_nxt;
        end
    end

    assign bus.obstacle_x_left  = x_left;
    assign bus.obstacle_x_right = x_right;
    assign bus.obstacle_y_up    = y_up;
    assign bus.obstacle_y_down  = y_down;
    assign bus.obstacles_passed = passed;
endmodule
